// File: rtl/seq_fano_decoder.sv
// seq_fano_decoder
//   Hard-decision Fano sequential decoder for the rate-1/2 systematic
//   convolutional code (constraint length K, parity taps G_MASK).
//   It buffers one frame of {systematic, parity} pairs, searches the code
//   tree with the Fano threshold algorithm, and then streams out the
//   decoded info bits. Differential decoding of the output is optional.
//
// Ports
//   clk        clock
//   reset_n    synchronous reset, active low
//   i_diff_en  1 = differential-decode the output (sampled on entry to output phase)
//   i_vld      input symbol pair valid
//   i_data     [1] systematic bit, [0] parity bit
//   o_rdy      decoder accepts a pair (transfer on i_vld & o_rdy)
//   o_vld      decoded bit valid (no backpressure)
//   o_data     decoded info bit, depth 0 first
//   o_last     marks the N_INFO-th decoded bit
//   o_err      frame hit the cycle budget; output is the raw systematic bits
module seq_fano_decoder #(
   parameter int             K       = 12,
   parameter logic [K-1:0]   G_MASK  = 12'hD35,
   parameter int             N_INFO  = 64,
   parameter int             DELTA   = 4,
   parameter int             M_AGR   = 1,
   parameter int             M_DIS   = 9,
   parameter int             MW      = 16,
   parameter int             MAX_CYC = 4096
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_diff_en,
   input  logic       i_vld,
   input  logic [1:0] i_data,
   output logic       o_rdy,
   output logic       o_vld,
   output logic       o_data,
   output logic       o_last,
   output logic       o_err
);

   localparam int NF = N_INFO + K - 1;          // pairs per frame incl. zero tail
   localparam int TW = $clog2(NF + 1);
   localparam int CW = $clog2(MAX_CYC + 1);

   localparam logic [TW-1:0] T_LAST = TW'(NF - 1);
   localparam logic [TW-1:0] T_INFO = TW'(N_INFO);
   localparam logic [TW-1:0] O_LAST = TW'(N_INFO - 1);
   localparam logic [CW-1:0] C_LAST = CW'(MAX_CYC - 1);

   localparam logic signed [MW-1:0] BM_A  = MW'(M_AGR);
   localparam logic signed [MW-1:0] BM_D  = MW'(M_DIS);
   localparam logic signed [MW-1:0] DLT   = MW'(DELTA);
   localparam logic signed [MW-1:0] S_MAX = {1'b0, {(MW-1){1'b1}}};
   localparam logic signed [MW-1:0] S_MIN = {1'b1, {(MW-1){1'b0}}};

   typedef enum logic [1:0] {S_LOAD, S_SEARCH, S_OUT} state_e;
   // MD_BEST: forward test of best branch, MD_NEXT: forward test of the
   // other branch, MD_BACK: no forward test, only look back from this node
   typedef enum logic [1:0] {MD_BEST, MD_NEXT, MD_BACK} mode_e;

   // saturating signed add; metrics and threshold must never wrap
   function automatic logic signed [MW-1:0] sadd(input logic signed [MW-1:0] a,
                                                 input logic signed [MW-1:0] b);
      logic [MW:0] s;
      s = {a[MW-1], a} + {b[MW-1], b};
      if (s[MW] != s[MW-1]) return s[MW] ? S_MIN : S_MAX;
      return s[MW-1:0];
   endfunction

   // branch metric; st[0] is the hypothesised bit, st[j] the bit j steps back
   function automatic logic signed [MW-1:0] bmet(input logic [K-1:0] st,
                                                 input logic s, input logic p);
      logic signed [MW-1:0] a, b;
      a = (st[0] == s) ? BM_A : -BM_D;
      b = ((^(st & G_MASK)) == p) ? BM_A : -BM_D;
      return a + b;
   endfunction

   state_e               state_q, state_d;
   mode_e                mode_q;
   logic [NF-1:0]        sys_q, par_q, path_q, worse_q;
   logic [TW-1:0]        ld_q, t_q, ocnt_q;
   logic [CW-1:0]        cyc_q;
   logic signed [MW-1:0] m_q, thr_q;
   logic                 err_q, diff_q, prev_q;
   logic                 o_rdy_q, o_vld_q, o_data_q, o_last_q;
   logic                 o_rdy_d, o_vld_d, o_data_d, o_last_d;

   logic                 xfer;
   logic [K:1]           win;      // win[j] = path bit at depth t-j, 0 above root
   logic [K-1:0]         pst;
   logic [TW-1:0]        tp;
   logic signed [MW-1:0] bm0, bm1, bm_try, bm_par, m_fwd, m_par, thr_up;
   logic                 best, u_try, fwd_ok, tighten, back_ok, try_other;
   logic                 done, abort, out_bit;

   assign xfer = i_vld & o_rdy_q;

   always_comb begin
      win = '0;
      for (int j = 1; j <= K; j++) begin
         if (t_q >= TW'(j)) win[j] = path_q[t_q - TW'(j)];
      end
   end

   // one Fano move is evaluated per clock from the current node
   always_comb begin
      tp        = (t_q == '0) ? '0 : t_q - 1'b1;
      pst       = win[K:1];
      bm0       = bmet({win[K-1:1], 1'b0}, sys_q[t_q], par_q[t_q]);
      bm1       = bmet({win[K-1:1], 1'b1}, sys_q[t_q], par_q[t_q]);
      best      = (t_q < T_INFO) && (bm1 > bm0);      // tie and tail -> 0
      u_try     = (mode_q == MD_NEXT) ? ~best : best;
      bm_try    = u_try ? bm1 : bm0;
      m_fwd     = sadd(m_q, bm_try);
      fwd_ok    = (mode_q != MD_BACK) && (m_fwd >= thr_q);
      thr_up    = sadd(thr_q, DLT);
      tighten   = (m_q < thr_up) && (m_fwd >= thr_up);
      bm_par    = bmet(pst, sys_q[tp], par_q[tp]);
      m_par     = sadd(m_q, -bm_par);
      back_ok   = (t_q != '0) && (m_par >= thr_q);
      try_other = !worse_q[tp] && (tp < T_INFO);
      done      = fwd_ok && (t_q == T_LAST);
      abort     = !done && (cyc_q == C_LAST);
   end

   // state register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_LOAD;
      else          state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:   if (xfer && ld_q == T_LAST) state_d = S_SEARCH;
         S_SEARCH: if (done || abort)          state_d = S_OUT;
         S_OUT:    if (ocnt_q == O_LAST)       state_d = S_LOAD;
         default:  state_d = S_LOAD;
      endcase
   end

   // outputs (registered below)
   always_comb begin
      out_bit  = err_q ? sys_q[ocnt_q] : path_q[ocnt_q];
      o_rdy_d  = (state_q == S_LOAD) && !(xfer && ld_q == T_LAST);
      o_vld_d  = (state_q == S_OUT);
      o_last_d = o_vld_d && (ocnt_q == O_LAST);
      o_data_d = o_vld_d ? (out_bit ^ (diff_q & prev_q)) : o_data_q;
   end

   // frame and path buffers are deliberately not reset
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD && xfer) begin
         sys_q[ld_q] <= i_data[1];
         par_q[ld_q] <= i_data[0];
      end
      if (state_q == S_SEARCH && fwd_ok) begin
         path_q[t_q]  <= u_try;
         worse_q[t_q] <= (mode_q == MD_NEXT);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         o_rdy_q  <= 1'b1;
         o_vld_q  <= 1'b0;
         o_data_q <= 1'b0;
         o_last_q <= 1'b0;
         err_q    <= 1'b0;
         diff_q   <= 1'b0;
         prev_q   <= 1'b0;
         ld_q     <= '0;
         t_q      <= '0;
         ocnt_q   <= '0;
         cyc_q    <= '0;
         m_q      <= '0;
         thr_q    <= '0;
         mode_q   <= MD_BEST;
      end else begin
         o_rdy_q  <= o_rdy_d;
         o_vld_q  <= o_vld_d;
         o_data_q <= o_data_d;
         o_last_q <= o_last_d;
         case (state_q)
            S_LOAD: begin
               if (xfer) ld_q <= ld_q + 1'b1;
               t_q    <= '0;
               m_q    <= '0;
               thr_q  <= '0;
               cyc_q  <= '0;
               mode_q <= MD_BEST;
            end
            S_SEARCH: begin
               cyc_q <= cyc_q + 1'b1;
               if (fwd_ok) begin
                  t_q    <= t_q + 1'b1;
                  m_q    <= m_fwd;
                  mode_q <= MD_BEST;
                  if (tighten) thr_q <= thr_up;
               end else if (!back_ok) begin
                  // root reached or parent below threshold: loosen and retry
                  thr_q  <= sadd(thr_q, -DLT);
                  mode_q <= MD_BEST;
               end else begin
                  t_q    <= tp;
                  m_q    <= m_par;
                  mode_q <= try_other ? MD_NEXT : MD_BACK;
               end
               if (state_d == S_OUT) begin
                  ocnt_q <= '0;
                  err_q  <= !done;
                  diff_q <= i_diff_en;
               end
            end
            S_OUT: begin
               ocnt_q <= ocnt_q + 1'b1;
               prev_q <= out_bit;
               if (state_d == S_LOAD) ld_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_rdy  = o_rdy_q;
   assign o_vld  = o_vld_q;
   assign o_data = o_data_q;
   assign o_last = o_last_q;
   assign o_err  = err_q;

endmodule

// File: tb/tb_seq_fano_decoder.sv
// tb_seq_fano_decoder
//   Scoreboard bench for seq_fano_decoder. Stimulus pushes the expected
//   output bits of each frame into a queue; a negedge monitor pops and
//   compares whenever a decoder presents o_vld. u0 uses the default cycle
//   budget, u1 a budget of 256 for the abort case.
module tb_seq_fano_decoder;
   localparam int K  = 12;
   localparam logic [K-1:0] G = 12'hD35;
   localparam int N  = 64;
   localparam int NF = N + K - 1;

   typedef struct packed { logic d; logic l; logic e; } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       diff_en = 1'b0;
   logic       vld0 = 1'b0, vld1 = 1'b0;
   logic [1:0] dat0 = 2'b00, dat1 = 2'b00;
   logic       rdy0, ov0, od0, ol0, oe0;
   logic       rdy1, ov1, od1, ol1, oe1;
   int         n_tests = 0, n_fail = 0;
   exp_t       q0[$], q1[$];
   exp_t       x0, x1;

   seq_fano_decoder u0 (.clk(clk), .reset_n(reset_n), .i_diff_en(diff_en),
      .i_vld(vld0), .i_data(dat0), .o_rdy(rdy0), .o_vld(ov0), .o_data(od0),
      .o_last(ol0), .o_err(oe0));

   seq_fano_decoder #(.MAX_CYC(256)) u1 (.clk(clk), .reset_n(reset_n),
      .i_diff_en(diff_en), .i_vld(vld1), .i_data(dat1), .o_rdy(rdy1),
      .o_vld(ov1), .o_data(od1), .o_last(ol1), .o_err(oe1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic void encode(input logic [N-1:0] src,
                                  output logic [NF-1:0] s, output logic [NF-1:0] p);
      logic [K-1:0] st;
      st = '0;
      for (int i = 0; i < NF; i++) begin
         logic b;
         if (i < N) b = src[i];
         else       b = 1'b0;
         st   = {st[K-2:0], b};
         s[i] = b;
         p[i] = ^(st & G);
      end
   endfunction

   function automatic logic [N-1:0] diffenc(input logic [N-1:0] src, input logic init);
      logic pv;
      logic [N-1:0] d;
      pv = init;
      for (int i = 0; i < N; i++) begin
         d[i] = src[i] ^ pv;
         pv   = d[i];
      end
      return d;
   endfunction

   task automatic push(input int k, input logic [N-1:0] bits, input logic err);
      for (int i = 0; i < N; i++) begin
         exp_t x;
         x.d = bits[i];
         x.l = (i == N - 1);
         x.e = err;
         if (k == 0) q0.push_back(x);
         else        q1.push_back(x);
      end
   endtask

   // starts and ends on a negedge; returns just after the last pair's edge
   task automatic load(input int k, input logic [NF-1:0] s, input logic [NF-1:0] p);
      int stalled;
      stalled = 0;
      for (int i = 0; i < NF; i++) begin
         int w;
         w = 0;
         if (k == 0) begin vld0 = 1'b1; dat0 = {s[i], p[i]}; end
         else        begin vld1 = 1'b1; dat1 = {s[i], p[i]}; end
         while (!(k == 0 ? rdy0 : rdy1) && w < 400) begin @(negedge clk); w++; end
         if (w >= 400) stalled++;
         @(negedge clk);
      end
      vld0 = 1'b0;
      vld1 = 1'b0;
      chk("load_stalls", stalled, 0);
   endtask

   task automatic run_out(input int k, output int lat);
      int w;
      lat = 0;
      while (!(k == 0 ? ov0 : ov1) && lat < 6000) begin @(negedge clk); lat++; end
      chk("vld_within_budget", lat < 6000, 1);
      w = 0;
      while (!(k == 0 ? ol0 : ol1) && w < 200) begin @(negedge clk); w++; end
      chk("last_on_64th", w, 63);
      vld0 = 1'b0;
      @(negedge clk);
      chk("vld0_rdy1_after_last", (k == 0) ? {ov0, rdy0} : {ov1, rdy1}, 2'b01);
   endtask

   always @(negedge clk) begin
      if (ov0) begin
         chk("u0_vld_expected", q0.size() > 0, 1);
         if (q0.size() > 0) begin
            x0 = q0.pop_front();
            chk("u0_bit{data,last,err}", {od0, ol0, oe0}, {x0.d, x0.l, x0.e});
         end
      end
      if (ov1) begin
         chk("u1_vld_expected", q1.size() > 0, 1);
         if (q1.size() > 0) begin
            x1 = q1.pop_front();
            chk("u1_bit{data,last,err}", {od1, ol1, oe1}, {x1.d, x1.l, x1.e});
         end
      end
   end

   initial begin
      logic [NF-1:0] s, p;
      logic [N-1:0]  src, d1, d2;
      logic          prev_m;
      int            lat;
      prev_m = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset_u0", {rdy0, ov0, od0, ol0, oe0}, 5'b10000);
      chk("reset_u1", {rdy1, ov1, od1, ol1, oe1}, 5'b10000);
      reset_n = 1'b1;
      @(negedge clk);

      // abort: every parity inverted, 256-cycle budget
      src = 64'h2718_2818_2845_9045;
      encode(src, s, p);
      p = ~p;
      push(1, src, 1'b1);
      load(1, s, p);
      run_out(1, lat);
      chk("t3_abort_latency", lat, 257);

      // error-free frame
      src = 64'hC3A5_1F0E_9B27_64D8;
      encode(src, s, p);
      push(0, src, 1'b0);
      load(0, s, p);
      run_out(0, lat);
      chk("t1_latency", lat, 76);
      prev_m = src[N-1];

      // sys error @10, parity error @30, both @50
      src = 64'h0123_4567_89AB_CDEF;
      encode(src, s, p);
      s[10] = ~s[10];
      p[30] = ~p[30];
      s[50] = ~s[50];
      p[50] = ~p[50];
      push(0, src, 1'b0);
      load(0, s, p);
      run_out(0, lat);
      chk("t2_backtracked", lat > 76, 1);
      prev_m = src[N-1];

      // i_vld held high with junk during search/output must not be consumed
      src = 64'hFEDC_BA98_7654_3210;
      encode(src, s, p);
      push(0, src, 1'b0);
      load(0, s, p);
      vld0 = 1'b1;
      dat0 = 2'b10;
      run_out(0, lat);
      src = 64'hDEAD_BEEF_CAFE_F00D;
      encode(src, s, p);
      push(0, src, 1'b0);
      load(0, s, p);
      run_out(0, lat);
      chk("t5_next_latency", lat, 76);
      prev_m = src[N-1];

      // differential stream over two back-to-back frames
      diff_en = 1'b1;
      src = 64'h5A5A_3C3C_0FF0_9669;
      d1  = diffenc(src, prev_m);
      encode(d1, s, p);
      push(0, src, 1'b0);
      load(0, s, p);
      run_out(0, lat);
      src = 64'h8001_7FFE_1234_ABCD;
      d2  = diffenc(src, d1[N-1]);
      encode(d2, s, p);
      push(0, src, 1'b0);
      load(0, s, p);
      run_out(0, lat);
      chk("t4_latency", lat, 76);
      diff_en = 1'b0;

      // one-clock reset in the middle of a search
      src = 64'hA5A5_A5A5_A5A5_A5A5;
      encode(src, s, p);
      load(0, s, p);
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("t6_after_reset{vld,rdy}", {ov0, rdy0}, 2'b01);
      src = 64'h3141_5926_5358_9793;
      encode(src, s, p);
      push(0, src, 1'b0);
      load(0, s, p);
      run_out(0, lat);
      chk("t6_fresh_latency", lat, 76);

      repeat (2) @(negedge clk);
      chk("u0_queue_drained", q0.size(), 0);
      chk("u1_queue_drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete, tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule
